// File: rtl/bleuart_tx_serializer.sv
// Byte-to-serial UART transmitter for the BLE module link: valid/ready byte intake,
// 8-bit LSB-first frames with optional parity, 1 or 2 stop bits, optional CTS gating.
module bleuart_tx_serializer #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned USE_CTS      = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_rdy,
    input  logic       cts_n,
    output logic       tx,
    output logic       busy
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic STOP_LAST = 1'(STOP_BITS - 1);

    // Reject unsupported configurations at elaboration
    if (PARITY > 2 || (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 2) begin : g_param_check
        $error("bleuart_tx_serializer: invalid PARITY, STOP_BITS or CLKS_PER_BIT");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic             stop_q, stop_d;
    logic [7:0]       shift_q, shift_d;
    logic             par_q, par_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             cts_meta_q, cts_sync_q;
    logic             cts_ok;
    logic             accept;
    logic             baud_last;

    assign cts_ok    = (USE_CTS != 0) ? ~cts_sync_q : 1'b1;
    assign data_rdy  = rst & (state_q == S_IDLE) & cts_ok;
    assign accept    = data_valid & data_rdy;
    assign baud_last = (baud_q == CNT_LAST);
    assign tx        = tx_q;
    assign busy      = busy_q;

    // Two-flop synchronizer for the asynchronous clear-to-send input
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cts_meta_q <= 1'b1;
            cts_sync_q <= 1'b1;
        end else begin
            cts_meta_q <= cts_n;
            cts_sync_q <= cts_meta_q;
        end
    end

    // Frame state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            stop_q  <= 1'b0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            stop_q  <= stop_d;
            shift_q <= shift_d;
            par_q   <= par_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
        end
    end

    // Next-state decode; tx_d carries the level for the cycle after each transition
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        stop_d  = stop_q;
        shift_d = shift_q;
        par_d   = par_q;
        tx_d    = tx_q;
        busy_d  = busy_q;

        unique case (state_q)
            S_IDLE: begin
                baud_d = '0;
                tx_d   = 1'b1;
                busy_d = 1'b0;
                if (accept) begin
                    shift_d = data_in;
                    par_d   = (PARITY == 2) ? ~^data_in : ^data_in;
                    bit_d   = '0;
                    stop_d  = 1'b0;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = shift_q[0];
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        if (PARITY != 0) begin
                            tx_d    = par_q;
                            state_d = S_PARITY;
                        end else begin
                            tx_d    = 1'b1;
                            state_d = S_STOP;
                        end
                    end else begin
                        bit_d   = 3'(bit_q + 3'd1);
                        shift_d = {1'b0, shift_q[7:1]};
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_PARITY: begin
                if (baud_last) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (stop_q == STOP_LAST) begin
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        stop_d = 1'b1;
                    end
                end
            end
            default: begin
                baud_d  = '0;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_bleuart_tx_serializer.sv
// Bench for bleuart_tx_serializer: three instances cover parity none/even/odd,
// one and two stop bits, and CTS gating; frames are decoded and scored against a queue.
module tb_bleuart_tx_serializer;

    localparam int unsigned C = 4;

    logic       clk;
    logic       rst;
    logic [7:0] din   [3];
    logic       dv    [3];
    logic       cts_n [3];
    logic       rdy   [3];
    logic       txw   [3];
    logic       bsy   [3];

    int         total;
    int         bad;
    logic [7:0] exp_q[$];
    int         gap_a;
    int         gap_b;

    // Instance 0: no parity, 1 stop; 1: even, 2 stops, CTS; 2: odd, 1 stop
    for (genvar g = 0; g < 3; g++) begin : g_dut
        bleuart_tx_serializer #(
            .CLKS_PER_BIT(C),
            .PARITY      (g),
            .STOP_BITS   ((g == 1) ? 2 : 1),
            .USE_CTS     ((g == 1) ? 1 : 0)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .data_in   (din[g]),
            .data_valid(dv[g]),
            .data_rdy  (rdy[g]),
            .cts_n     (cts_n[g]),
            .tx        (txw[g]),
            .busy      (bsy[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Offer a byte; on acceptance the byte becomes the next expected frame
    task automatic send(input int idx, input logic [7:0] b, input bit hold);
        bit ok;
        ok       = 1'b0;
        din[idx] = b;
        dv[idx]  = 1'b1;
        for (int k = 0; k < 300; k++) begin
            if (rdy[idx] === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            check($sformatf("send%0d_timeout", idx), 32'd0, 32'd1);
            dv[idx] = 1'b0;
            return;
        end
        @(posedge clk);
        exp_q.push_back(b);
        #1;
        if (!hold) dv[idx] = 1'b0;
    endtask

    // Decode one frame cycle by cycle and compare with the scoreboard head
    task automatic rx_frame(input int idx, input int exp_rdy, output int gap);
        int         nb;
        int         j;
        logic [11:0] ebit;
        logic [7:0] b;
        logic [C-1:0] obs;
        bit         found;
        bit         busy_all;
        bit         busy_pre;
        gap      = 0;
        found    = 1'b0;
        busy_all = 1'b1;
        busy_pre = 1'b0;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if (txw[idx] === 1'b0) begin
                found = 1'b1;
                break;
            end
            gap++;
            if (bsy[idx] !== 1'b0) busy_pre = 1'b1;
        end
        if (!found) begin
            check($sformatf("rx%0d_start_timeout", idx), 32'd0, 32'd1);
            return;
        end
        if (exp_q.size() == 0) begin
            check($sformatf("rx%0d_unexpected_frame", idx), 32'd1, 32'd0);
            return;
        end
        b       = exp_q.pop_front();
        ebit    = '0;
        ebit[0] = 1'b0;
        for (int i = 0; i < 8; i++) ebit[1+i] = b[i];
        j = 9;
        if (idx != 0) begin
            ebit[j] = (idx == 1) ? ^b : ~^b;
            j++;
        end
        for (int s = 0; s < ((idx == 1) ? 2 : 1); s++) begin
            ebit[j] = 1'b1;
            j++;
        end
        nb = j;
        for (int n = 0; n < nb; n++) begin
            obs = '0;
            for (int c = 0; c < int'(C); c++) begin
                if (n != 0 || c != 0) @(negedge clk);
                obs[c] = txw[idx];
                if (bsy[idx] !== 1'b1) busy_all = 1'b0;
            end
            check($sformatf("rx%0d_byte%02h_bit%0d", idx, b, n), 32'(obs), 32'({C{ebit[n]}}));
        end
        check($sformatf("rx%0d_busy_before", idx), 32'(busy_pre), 32'd0);
        check($sformatf("rx%0d_busy_frame", idx), 32'(busy_all), 32'd1);
        @(negedge clk);
        check($sformatf("rx%0d_idle_tx", idx), 32'(txw[idx]), 32'd1);
        check($sformatf("rx%0d_idle_busy", idx), 32'(bsy[idx]), 32'd0);
        if (exp_rdy >= 0) check($sformatf("rx%0d_idle_rdy", idx), 32'(rdy[idx]), 32'(exp_rdy));
    endtask

    initial begin
        bit quiet;
        bit blocked;
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            din[i]   = 8'h00;
            dv[i]    = 1'b0;
            cts_n[i] = 1'b1;
        end
        cts_n[1] = 1'b0;

        // Power-on reset and release
        repeat (3) @(negedge clk);
        check("por_tx", 32'(txw[0]), 32'd1);
        check("por_busy", 32'(bsy[0]), 32'd0);
        check("por_rdy", 32'(rdy[0]), 32'd0);
        rst = 1'b1;
        #1;
        check("rel_rdy_nocts", 32'(rdy[0]), 32'd1);
        check("rel_rdy_cts_sync", 32'(rdy[1]), 32'd0);

        // Reset asserted mid-idle
        repeat (3) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        check("idle_rst_tx", 32'(txw[0]), 32'd1);
        check("idle_rst_busy", 32'(bsy[0]), 32'd0);
        check("idle_rst_rdy", 32'(rdy[0]), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("idle_rel_rdy", 32'(rdy[0]), 32'd1);
        repeat (3) @(negedge clk);
        check("cts_low_rdy", 32'(rdy[1]), 32'd1);

        // Plain 8N1 frame
        fork
            send(0, 8'hA5, 1'b0);
            rx_frame(0, 1, gap_a);
        join

        // Even parity with two stop bits, then odd parity
        fork
            send(1, 8'h07, 1'b0);
            rx_frame(1, 1, gap_a);
        join
        fork
            send(2, 8'h07, 1'b0);
            rx_frame(2, 1, gap_a);
        join

        // Back-to-back frames with data_valid held
        fork
            begin
                send(0, 8'h55, 1'b1);
                send(0, 8'hAA, 1'b0);
            end
            begin
                rx_frame(0, 1, gap_a);
                rx_frame(0, 1, gap_b);
                check("b2b_gap", 32'(gap_b), 32'd0);
            end
        join
        quiet = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (txw[0] !== 1'b1 || bsy[0] !== 1'b0) quiet = 1'b0;
        end
        check("b2b_no_extra_frame", 32'(quiet), 32'd1);
        check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

        // CTS gating
        cts_n[1] = 1'b1;
        repeat (3) @(negedge clk);
        din[1]  = 8'hC3;
        dv[1]   = 1'b1;
        blocked = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (rdy[1] !== 1'b0 || txw[1] !== 1'b1 || bsy[1] !== 1'b0) blocked = 1'b0;
        end
        check("cts_blocked", 32'(blocked), 32'd1);
        #1 cts_n[1] = 1'b0;
        @(negedge clk);
        check("cts_rdy_1cyc", 32'(rdy[1]), 32'd0);
        @(negedge clk);
        check("cts_rdy_2cyc", 32'(rdy[1]), 32'd1);
        fork
            send(1, 8'hC3, 1'b0);
            rx_frame(1, 0, gap_a);
            begin
                repeat (14) @(negedge clk);
                cts_n[1] = 1'b1;
            end
        join

        // Reset during data bit 3, byte re-offered afterwards
        send(0, 8'h3C, 1'b1);
        repeat ((1 + 3) * C + 2) @(negedge clk);
        check("pre_rst_busy", 32'(bsy[0]), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("mid_rst_tx", 32'(txw[0]), 32'd1);
        check("mid_rst_busy", 32'(bsy[0]), 32'd0);
        check("mid_rst_rdy", 32'(rdy[0]), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst = 1'b1;
        #1;
        fork
            send(0, 8'h3C, 1'b0);
            rx_frame(0, 1, gap_a);
        join
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
